cipher_frame_rx: RTL

- UART receive front end for the 8-bit decrypt datapath.
- Deserialises a two-byte frame from the serial line: byte 0 is the key, byte 1 is the ciphertext.
- Presents the key/ciphertext pair to the combinational decrypt stage, with a one-cycle valid strobe.
- Handles start-bit validation, framing errors and inter-byte timeout, so the downstream stage only ever sees complete, well-formed pairs.

---
 rtl/cipher_frame_rx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cipher_frame_rx.sv
// UART 8N1 receiver that pairs two bytes (key, ciphertext) into one frame for the decrypt stage.
// Handles false starts, bad stop bits and a pending-key timeout.
module cipher_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 1250,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] key_out,
  output logic [7:0] data_out,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       timeout,
  output logic       busy
);

  localparam int unsigned HalfBit  = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned TmoLimit = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
  localparam int unsigned TmoW     = $clog2(TmoLimit);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StRecover
  } state_e;

  state_e          state;
  logic            rx_meta;
  logic            rxs;
  logic [CntW-1:0] clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [7:0]      held_key;
  logic            slot;
  logic [TmoW-1:0] tmo_cnt;

  logic bit_done;
  logic half_done;
  logic tmo_expire;

  assign bit_done   = (clk_cnt == CntW'(CLKS_PER_BIT - 1));
  assign half_done  = (clk_cnt == CntW'(HalfBit));
  assign tmo_expire = (tmo_cnt == TmoW'(TmoLimit - 1));

  assign busy = (state != StIdle) || slot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= StIdle;
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      held_key    <= '0;
      slot        <= 1'b0;
      tmo_cnt     <= '0;
      key_out     <= '0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rxs         <= rx_meta;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;

      unique case (state)
        StIdle: begin
          // Expiry and a start edge in the same cycle: expiry wins and the
          // incoming byte becomes a fresh key because slot is cleared here.
          if (slot) begin
            if (tmo_expire) begin
              timeout <= 1'b1;
              slot    <= 1'b0;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          if (!rxs) begin
            state   <= StStart;
            clk_cnt <= '0;
          end
        end

        StStart: begin
          if (half_done) begin
            clk_cnt <= '0;
            if (!rxs) begin
              state   <= StData;
              bit_idx <= '0;
              tmo_cnt <= '0;
            end else begin
              state <= StIdle;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        StData: begin
          if (bit_done) begin
            clk_cnt <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= StStop;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        StStop: begin
          if (bit_done) begin
            clk_cnt <= '0;
            if (rxs) begin
              state <= StIdle;
              if (slot) begin
                key_out     <= held_key;
                data_out    <= shreg;
                frame_valid <= 1'b1;
                slot        <= 1'b0;
              end else begin
                held_key <= shreg;
                slot     <= 1'b1;
                tmo_cnt  <= '0;
              end
            end else begin
              frame_err <= 1'b1;
              slot      <= 1'b0;
              held_key  <= '0;
              state     <= StRecover;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        StRecover: begin
          // Hold off until the line returns high so a break is not taken as a start bit.
          if (rxs) begin
            state <= StIdle;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule
